// File: rtl/data_ram_resp.sv
// Data-memory responder for the memory stage: one word request at a time,
// fixed wait states, single-cycle ack, and a stall request while busy.
module data_ram_resp #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stallreq_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  generate
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_ram_resp: WAIT_CYCLES must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr
      $error("data_ram_resp: ADDR_W must be in 1..29");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [3:0]        req_sel;
  logic [31:0]       req_data;
  logic [31:0]       mem [DEPTH];

  logic              in_range_c;
  logic [ADDR_W-1:0] idx_c;
  logic              access_c;
  logic              write_c;

  // Everything above the word index must be zero for an in-range access.
  assign in_range_c = (req_addr >> (ADDR_W + 2)) == 32'd0;
  assign idx_c      = req_addr[ADDR_W+1:2];
  assign access_c   = (state == BUSY) && (cnt == '0);
  assign write_c    = rst && access_c && req_we && in_range_c;

  assign stallreq_o = rst && mem_ce_i && (state != ACK);

  // Byte-lane store into the word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_c) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) begin
          mem[idx_c][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  // Request capture, wait-state countdown and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_sel    <= '0;
      req_data   <= '0;
      mem_data_o <= '0;
      mem_ack_o  <= 1'b0;
      mem_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack_o  <= 1'b0;
          mem_err_o  <= 1'b0;
          mem_data_o <= '0;
          if (mem_ce_i) begin
            req_we   <= mem_we_i;
            req_addr <= mem_addr_i;
            req_sel  <= mem_sel_i;
            req_data <= mem_data_i;
            cnt      <= CNT_W'(WAIT_CYCLES);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= ACK;
            mem_ack_o  <= 1'b1;
            mem_err_o  <= !in_range_c;
            mem_data_o <= (!req_we && in_range_c) ? mem[idx_c] : 32'd0;
          end
        end
        ACK: begin
          state      <= IDLE;
          mem_ack_o  <= 1'b0;
          mem_err_o  <= 1'b0;
          mem_data_o <= '0;
        end
        default: begin
          state      <= IDLE;
          mem_ack_o  <= 1'b0;
          mem_err_o  <= 1'b0;
          mem_data_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder on the far side of the memory stage's load/store interface.
- Accepts one word-wide request at a time from the memory stage and performs it against an internal word array after a fixed number of wait states.
- Completes each request with a single-cycle ack.
- Raises a stall request toward the pipeline controller while an access is outstanding, so the memory-stage instruction is held until data returns.

Parameters:
ADDR_W, 10, word-index width; array depth = 2^ADDR_W words (default 4 KB)
WAIT_CYCLES, 2, wait states inserted before the access is performed; legal range 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
mem_ce_i  input  1  request valid from memory stage
mem_we_i  input  1  1 = store, 0 = load
mem_addr_i  input  32  byte address; bits [1:0] ignored
mem_sel_i  input  4  byte-lane enables; bit3 = data[31:24] ... bit0 = data[7:0]
mem_data_i  input  32  store data
mem_data_o  output  32  load data, valid while mem_ack_o = 1
mem_ack_o  output  1  one-cycle completion pulse
mem_err_o  output  1  address out of range, pulses together with mem_ack_o
stallreq_o  output  1  stall request to pipeline controller

Behaviour:
- Reset (rst = 0 at a rising edge):
  - state = IDLE, wait counter = 0.
  - mem_data_o = 0, mem_ack_o = 0, mem_err_o = 0.
  - Any captured request is discarded; an in-flight store is not committed.
  - Array contents are not cleared.
- States: IDLE, BUSY, ACK.
- IDLE:
  - With mem_ce_i = 1: capture we, addr, sel and data into request registers, load counter with WAIT_CYCLES, go to BUSY.
  - With mem_ce_i = 0: stay in IDLE.
- BUSY:
  - While counter != 0: decrement.
  - When counter == 0, perform the access and go to ACK.
    - Word index = addr[ADDR_W+1:2].
    - In range means addr[31:ADDR_W+2] == 0.
    - Store in range: write only the lanes whose sel bit = 1; unselected lanes are unchanged. mem_data_o = 0.
    - Load in range: mem_data_o = full stored word. sel is ignored; lane extraction and sign extension belong to the memory stage.
    - Out of range: no array write, mem_data_o = 0, mem_err_o = 1.
    - mem_ack_o = 1.
- ACK:
  - mem_ack_o, mem_data_o and mem_err_o are registered and valid for exactly this one cycle.
  - Next edge: go to IDLE, mem_ack_o = 0, mem_err_o = 0, mem_data_o = 0.
- Latency:
  - Request first seen at edge E.
  - mem_ack_o is high in the cycle following edge E + WAIT_CYCLES + 1.
  - WAIT_CYCLES = 0 gives ack in the 2nd cycle after presentation.
- stallreq_o (combinational) = mem_ce_i AND (state != ACK).
  - It deasserts in the ack cycle so the pipeline advances at the end of that cycle.
  - stallreq_o = 0 while rst = 0.
- Back-to-back requests:
  - The next request is accepted only from IDLE, one cycle after ACK. There is no pipelining of requests.
  - If mem_ce_i is still 1 in IDLE after ACK, it is treated as a new request.
- Request stability: the requester holds its inputs until ack. Inputs are captured at acceptance, so changes or deassertion of mem_ce_i during BUSY do not affect the access. An accepted request always completes and acks.
- sel = 4'b0000 store: acks normally, array unchanged.
- Counter is 4 bits. WAIT_CYCLES outside 0..15 is illegal; flag it with an elaboration-time check.

Test Plan:
- WAIT_CYCLES = 2. Store addr 0x10, data 0xDEADBEEF, sel 4'b1111, then load 0x10 → ack 4th cycle after each request; load returns 0xDEADBEEF; stallreq_o = 1 for the first 3 cycles of each request, 0 in the ack cycle.
- Partial store: word 0x20 preset to 0x11223344; store 0xAABBCCDD with sel 4'b0100 → subsequent load of 0x20 returns 0x11BB3344.
- Out of range (ADDR_W = 10): load at 0x00001000 → mem_ack_o = 1, mem_err_o = 1, mem_data_o = 0. Store there → array unchanged (spot-check word 0 keeps its prior value).
- Reset mid-operation: store to 0x30 accepted; rst = 0 during BUSY → state IDLE, outputs 0, no ack. Later load of 0x30 returns the pre-store value.
- WAIT_CYCLES = 0: load with mem_ce_i held high across two consecutive instructions → acks exactly 3 cycles apart (ack, IDLE accept, BUSY, ack). Dropping mem_ce_i mid-BUSY still yields an ack.
- Back-to-back store then load to the same address with no idle gap from the requester → load returns the newly stored data; one IDLE cycle is observed between ACK and the second acceptance.
